// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pattern generator / response compactor.
// Holds the phase encoding and the default polynomial and seed constants.
package bist_pkg;

  // Phase of the compaction sequence as seen from the controller strobes
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COMPACT = 2'd2,
    DONE    = 2'd3
  } phase_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_POLY = 16'hB400;
  localparam logic [DEF_WIDTH-1:0] DEF_SEED = 16'hACE1;

endpackage

// File: rtl/bist_galois_reg.sv
// Galois shift register, usable as a pattern LFSR (data tied to 0) or as a MISR.
// Ports:
//   clock, reset_n : rising-edge clock, synchronous active-low reset (to RESET_VAL)
//   load, load_val : load a value; takes priority over step
//   step, data     : advance one Galois step and XOR in data
//   value          : current register contents
module bist_galois_reg
  import bist_pkg::*;
#(
  parameter int unsigned            WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0]       POLY      = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] step_val;

  // Right-shifting Galois step; feedback taps applied when the LSB falls out
  always_comb begin
    step_val = (value >> 1) ^ (value[0] ? POLY : '0) ^ data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= step_val;
    end
  end

endmodule

// File: rtl/bist_pattern_compactor.sv
// BIST datapath: drives LFSR patterns into the CUT, compacts responses into a
// MISR signature and compares it against GOLDEN when the controller finishes.
// Ports:
//   clock, reset_n   : rising-edge clock, synchronous active-low reset
//   init             : restart strobe (seed LFSR, clear signature/count/flags)
//   mode             : apply and compact one pattern this cycle
//   running          : controller running indication (informational only)
//   finish           : end of test; latch pass/fail next cycle
//   cut_response     : combinational CUT response to test_pattern
//   test_pattern     : current LFSR value
//   signature        : current MISR value
//   pattern_count    : patterns compacted, saturating
//   result_valid     : pass/fail valid
//   pass, fail       : signature comparison result
//   protocol_err     : sticky illegal-strobe flag
module bist_pattern_compactor
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
  parameter logic [WIDTH-1:0] GOLDEN    = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             init,
  input  logic             mode,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_response,
  output logic [WIDTH-1:0] test_pattern,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pattern_count,
  output logic             result_valid,
  output logic             pass,
  output logic             fail,
  output logic             protocol_err
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  phase_t           phase_q, phase_d;
  logic             do_load, do_step;
  logic [CNT_W-1:0] cnt_d;
  logic             valid_d, pass_d, fail_d, perr_d;

  // Holding during round gaps is the default behaviour, so running carries no logic
  logic unused_running;
  assign unused_running = running;

  bist_galois_reg #(
    .WIDTH    (WIDTH),
    .POLY     (LFSR_POLY),
    .RESET_VAL(SEED_EFF)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (do_load),
    .load_val(SEED_EFF),
    .step    (do_step),
    .data    ('0),
    .value   (test_pattern)
  );

  bist_galois_reg #(
    .WIDTH    (WIDTH),
    .POLY     (MISR_POLY),
    .RESET_VAL('0)
  ) u_misr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (do_load),
    .load_val('0),
    .step    (do_step),
    .data    (cut_response),
    .value   (signature)
  );

  // Phase FSM, next-state and datapath controls; priority init > finish > mode
  always_comb begin
    phase_d = phase_q;
    do_load = 1'b0;
    do_step = 1'b0;
    cnt_d   = pattern_count;
    valid_d = result_valid;
    pass_d  = pass;
    fail_d  = fail;
    perr_d  = protocol_err;

    if (init) begin
      phase_d = ARMED;
      do_load = 1'b1;
      cnt_d   = '0;
      valid_d = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      perr_d  = 1'b0;
    end else if (finish) begin
      case (phase_q)
        COMPACT: begin
          // Compare the signature as it stands, before any same-cycle update
          phase_d = DONE;
          valid_d = 1'b1;
          pass_d  = (signature == GOLDEN);
          fail_d  = (signature != GOLDEN);
        end
        IDLE, ARMED: perr_d = 1'b1;
        default: ;
      endcase
    end else if (mode) begin
      case (phase_q)
        ARMED, COMPACT: begin
          phase_d = COMPACT;
          do_step = 1'b1;
          if (pattern_count != CNT_MAX) begin
            cnt_d = pattern_count + CNT_W'(1);
          end
        end
        default: perr_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q       <= IDLE;
      pattern_count <= '0;
      result_valid  <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      pattern_count <= cnt_d;
      result_valid  <= valid_d;
      pass          <= pass_d;
      fail          <= fail_d;
      protocol_err  <= perr_d;
    end
  end

endmodule

// File: tb/tb_bist_pattern_compactor.sv
// Directed bench for bist_pattern_compactor (WIDTH=16, CNT_W=8 so saturation is reachable).
module tb_bist_pattern_compactor;

  localparam int unsigned W      = 16;
  localparam int unsigned CW     = 8;
  localparam logic [15:0] POLY   = 16'hB400;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          ROUNDS = 7;
  localparam int          PER    = 10;

  // CUT stand-in: byte swap plus constant
  function automatic logic [15:0] cut_f(input logic [15:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] gstep(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 16'h0000);
  endfunction

  // Signature after a full run of ROUNDS*PER patterns, optionally with one response corrupted
  function automatic logic [15:0] model_sig(input logic [15:0] fmask, input int fidx);
    logic [15:0] tp;
    logic [15:0] sg;
    tp = SEED;
    sg = 16'h0000;
    for (int k = 0; k < ROUNDS * PER; k++) begin
      sg = gstep(sg) ^ cut_f(tp) ^ ((k == fidx) ? fmask : 16'h0000);
      tp = gstep(tp);
    end
    return sg;
  endfunction

  localparam logic [15:0] GOLD = model_sig(16'h0000, -1);

  logic          clock;
  logic          reset_n;
  logic          init, mode, running, finish;
  logic [W-1:0]  cut_response;
  logic [W-1:0]  test_pattern, signature;
  logic [CW-1:0] pattern_count;
  logic          result_valid, pass, fail, protocol_err;

  logic          use_model;
  logic [15:0]   resp_direct;
  logic [15:0]   flip_mask;

  int n_checks;
  int n_pass;

  bist_pattern_compactor #(
    .WIDTH    (W),
    .LFSR_POLY(POLY),
    .MISR_POLY(POLY),
    .SEED     (SEED),
    .GOLDEN   (GOLD),
    .CNT_W    (CW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .init         (init),
    .mode         (mode),
    .running      (running),
    .finish       (finish),
    .cut_response (cut_response),
    .test_pattern (test_pattern),
    .signature    (signature),
    .pattern_count(pattern_count),
    .result_valid (result_valid),
    .pass         (pass),
    .fail         (fail),
    .protocol_err (protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    cut_response = use_model ? (cut_f(test_pattern) ^ flip_mask) : resp_direct;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_full(input logic [15:0] fmask, input int fidx);
    int k;
    k = 0;
    use_model = 1'b1;
    init = 1'b1;
    tick();
    init = 1'b0;
    running = 1'b1;
    for (int r = 0; r < ROUNDS; r++) begin
      for (int p = 0; p < PER; p++) begin
        mode = 1'b1;
        flip_mask = (k == fidx) ? fmask : 16'h0000;
        tick();
        k++;
      end
      mode = 1'b0;
      flip_mask = 16'h0000;
      tick();
      tick();
    end
    chk("run_valid_before_finish", 32'(result_valid), 32'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    running = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset_n = 1'b0;
    init = 1'b0; mode = 1'b0; running = 1'b0; finish = 1'b0;
    use_model = 1'b0; resp_direct = 16'h0000; flip_mask = 16'h0000;

    // 1: reset state
    tick(); tick();
    chk("rst_pattern", 32'(test_pattern), 32'h0000ACE1);
    chk("rst_sig", 32'(signature), 32'd0);
    chk("rst_count", 32'(pattern_count), 32'd0);
    chk("rst_flags", {28'd0, result_valid, pass, fail, protocol_err}, 32'd0);
    reset_n = 1'b1;

    // 2: first two compaction steps
    init = 1'b1; tick(); init = 1'b0;
    resp_direct = 16'h1234; mode = 1'b1; tick(); mode = 1'b0;
    chk("step1_pattern", 32'(test_pattern), 32'h0000E270);
    chk("step1_sig", 32'(signature), 32'h00001234);
    chk("step1_count", 32'(pattern_count), 32'd1);
    resp_direct = 16'h0000; mode = 1'b1; tick(); mode = 1'b0;
    chk("step2_sig", 32'(signature), 32'h0000091A);
    chk("step2_pattern", 32'(test_pattern), 32'h00007138);
    chk("step2_count", 32'(pattern_count), 32'd2);
    running = 1'b1; tick(); running = 1'b0;
    chk("gap_hold_sig", 32'(signature), 32'h0000091A);

    // 3: full run with matching golden, then DONE behaviour
    run_full(16'h0000, -1);
    chk("run_valid", 32'(result_valid), 32'd1);
    chk("run_pass", 32'(pass), 32'd1);
    chk("run_fail", 32'(fail), 32'd0);
    chk("run_count", 32'(pattern_count), 32'(ROUNDS * PER));
    chk("run_sig", 32'(signature), 32'(GOLD));
    chk("run_perr", 32'(protocol_err), 32'd0);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("done_finish_ignored", {29'd0, result_valid, pass, protocol_err}, 32'd6);
    mode = 1'b1; tick(); mode = 1'b0;
    chk("done_mode_perr", 32'(protocol_err), 32'd1);
    chk("done_mode_sig_hold", 32'(signature), 32'(GOLD));
    chk("done_mode_cnt_hold", 32'(pattern_count), 32'(ROUNDS * PER));

    // 3b: one flipped response bit must fail
    run_full(16'h0001, 33);
    chk("bad_valid", 32'(result_valid), 32'd1);
    chk("bad_pass", 32'(pass), 32'd0);
    chk("bad_fail", 32'(fail), 32'd1);
    chk("bad_sig", 32'(signature), 32'(model_sig(16'h0001, 33)));
    use_model = 1'b0;

    // 4: init beats mode in the same cycle; phase left ARMED
    init = 1'b1; mode = 1'b1; resp_direct = 16'hFFFF; tick();
    init = 1'b0; mode = 1'b0;
    chk("initmode_pattern", 32'(test_pattern), 32'h0000ACE1);
    chk("initmode_count", 32'(pattern_count), 32'd0);
    chk("initmode_sig", 32'(signature), 32'd0);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("armed_finish_perr", 32'(protocol_err), 32'd1);
    chk("armed_finish_novalid", 32'(result_valid), 32'd0);

    // 5: reset in the middle of compaction
    init = 1'b1; tick(); init = 1'b0;
    use_model = 1'b1;
    mode = 1'b1;
    repeat (5) tick();
    mode = 1'b0;
    chk("mid_count5", 32'(pattern_count), 32'd5);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("midrst_pattern", 32'(test_pattern), 32'h0000ACE1);
    chk("midrst_sig", 32'(signature), 32'd0);
    chk("midrst_count", 32'(pattern_count), 32'd0);
    chk("midrst_flags", {28'd0, result_valid, pass, fail, protocol_err}, 32'd0);

    // 6: mode in IDLE is illegal and changes nothing else
    mode = 1'b1; tick(); mode = 1'b0;
    chk("idle_mode_perr", 32'(protocol_err), 32'd1);
    chk("idle_mode_pattern", 32'(test_pattern), 32'h0000ACE1);
    chk("idle_mode_count", 32'(pattern_count), 32'd0);
    init = 1'b1; tick(); init = 1'b0;
    chk("init_clears_perr", 32'(protocol_err), 32'd0);

    // Counter saturation at 2^CW-1
    mode = 1'b1;
    repeat (260) tick();
    chk("sat_count", 32'(pattern_count), 32'd255);
    tick();
    mode = 1'b0;
    chk("sat_hold", 32'(pattern_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
